// File: rtl/e203_icb2axi_pkg.sv
// Shared types and AXI encodings for the ICB-to-AXI64 bridge.
package e203_icb2axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_AR,
    ST_RD_R,
    ST_WR_AWW,
    ST_WR_B,
    ST_RSP
  } state_e;

  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0]  AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0]  AXI_RESP_SLVERR = 2'b10;
  localparam logic [15:0] TIMEOUT_MAX     = 16'hFFFF;

  // SLVERR and DECERR both carry bit 1; OKAY/EXOKAY do not.
  function automatic logic resp_err(input logic [1:0] resp, input logic id_bad);
    return (|(resp & AXI_RESP_SLVERR)) | id_bad;
  endfunction

endpackage

// File: rtl/e203_icb2axi_lane.sv
// 32<->64 bit lane steering, shared by the write and read directions.
module e203_icb2axi_lane (
  input  logic        lane,
  input  logic [31:0] wdata_in,
  input  logic [3:0]  wmask_in,
  input  logic [63:0] rdata_in,
  output logic [63:0] wdata_out,
  output logic [7:0]  wstrb_out,
  output logic [31:0] rdata_out
);
  assign wdata_out = {wdata_in, wdata_in};
  assign wstrb_out = lane ? {wmask_in, 4'b0000} : {4'b0000, wmask_in};
  assign rdata_out = lane ? rdata_in[63:32] : rdata_in[31:0];
endmodule

// File: rtl/e203_icb2axi64_bridge.sv
// ICB (32-bit) to single-beat AXI4 (64-bit) bridge, one transaction outstanding.
// Optional response timeout with stale-beat drain: define E203_ICB2AXI_TIMEOUT_EN.
module e203_icb2axi64_bridge
  import e203_icb2axi_pkg::*;
#(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            icb_cmd_valid,
  output logic            icb_cmd_ready,
  input  logic [31:0]     icb_cmd_addr,
  input  logic            icb_cmd_read,
  input  logic [31:0]     icb_cmd_wdata,
  input  logic [3:0]      icb_cmd_wmask,
  output logic            icb_rsp_valid,
  input  logic            icb_rsp_ready,
  output logic [31:0]     icb_rsp_rdata,
  output logic            icb_rsp_err,
  output logic            axi_arvalid,
  input  logic            axi_arready,
  output logic [31:0]     axi_araddr,
  output logic [ID_W-1:0] axi_arid,
  output logic [7:0]      axi_arlen,
  output logic [2:0]      axi_arsize,
  output logic [1:0]      axi_arburst,
  input  logic            axi_rvalid,
  output logic            axi_rready,
  input  logic [63:0]     axi_rdata,
  input  logic [1:0]      axi_rresp,
  input  logic            axi_rlast,
  input  logic [ID_W-1:0] axi_rid,
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [31:0]     axi_awaddr,
  output logic [ID_W-1:0] axi_awid,
  output logic [7:0]      axi_awlen,
  output logic [2:0]      axi_awsize,
  output logic [1:0]      axi_awburst,
  output logic            axi_wvalid,
  input  logic            axi_wready,
  output logic [63:0]     axi_wdata,
  output logic [7:0]      axi_wstrb,
  output logic            axi_wlast,
  input  logic            axi_bvalid,
  output logic            axi_bready,
  input  logic [1:0]      axi_bresp,
  input  logic [ID_W-1:0] axi_bid
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, wdata_q, rsp_rdata_q;
  logic [3:0]  wmask_q;
  logic        read_q, lane_q, rsp_err_q, cmd_rdy_q;
  logic        arvalid_q, awvalid_q, wvalid_q, aw_done_q, w_done_q;
  logic        cmd_hs, ar_hs, aw_hs, w_hs, r_beat, b_beat;
  logic        aw_done_d, w_done_d, tmo_hit, draining;
  logic [31:0] lane_rdata;
  logic        unused_rlast;

  assign unused_rlast = axi_rlast;

  e203_icb2axi_lane u_lane (
    .lane      (lane_q),
    .wdata_in  (wdata_q),
    .wmask_in  (wmask_q),
    .rdata_in  (axi_rdata),
    .wdata_out (axi_wdata),
    .wstrb_out (axi_wstrb),
    .rdata_out (lane_rdata)
  );

  assign cmd_hs    = icb_cmd_valid & cmd_rdy_q;
  assign ar_hs     = arvalid_q & axi_arready;
  assign aw_hs     = awvalid_q & axi_awready;
  assign w_hs      = wvalid_q & axi_wready;
  assign r_beat    = (state_q == ST_RD_R) & axi_rvalid;
  assign b_beat    = (state_q == ST_WR_B) & axi_bvalid;
  assign aw_done_d = aw_done_q | aw_hs;
  assign w_done_d  = w_done_q | w_hs;

`ifdef E203_ICB2AXI_TIMEOUT_EN
  logic [15:0] cnt_q;
  logic        drain_q, wait_st;

  assign wait_st  = (state_q == ST_RD_R) | (state_q == ST_WR_B);
  assign tmo_hit  = wait_st & (cnt_q == TIMEOUT_MAX) & ~(r_beat | b_beat);
  assign draining = drain_q;

  // The drain flag stays up until the abandoned R/B beat has been swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      drain_q <= 1'b0;
    end else begin
      cnt_q   <= (wait_st && state_d == state_q) ? cnt_q + 16'd1 : 16'd0;
      drain_q <= tmo_hit | (drain_q & ~(axi_rvalid | axi_bvalid));
    end
  end
`else
  assign tmo_hit  = 1'b0;
  assign draining = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cmd_hs) state_d = icb_cmd_read ? ST_RD_AR : ST_WR_AWW;
      ST_RD_AR:  if (ar_hs) state_d = ST_RD_R;
      ST_RD_R:   if (r_beat || tmo_hit) state_d = ST_RSP;
      ST_WR_AWW: if (aw_done_d && w_done_d) state_d = ST_WR_B;
      ST_WR_B:   if (b_beat || tmo_hit) state_d = ST_RSP;
      ST_RSP:    if (icb_rsp_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    icb_cmd_ready = cmd_rdy_q;
    icb_rsp_valid = (state_q == ST_RSP);
    icb_rsp_rdata = read_q ? rsp_rdata_q : 32'd0;
    icb_rsp_err   = rsp_err_q;
    axi_arvalid   = arvalid_q;
    axi_awvalid   = awvalid_q;
    axi_wvalid    = wvalid_q;
    axi_rready    = (state_q == ST_RD_R) | draining;
    axi_bready    = (state_q == ST_WR_B) | draining;
    axi_araddr    = addr_q;
    axi_awaddr    = addr_q;
    axi_arid      = AXI_ID;
    axi_awid      = AXI_ID;
    axi_arlen     = 8'd0;
    axi_awlen     = 8'd0;
    axi_arsize    = AXI_SIZE_4B;
    axi_awsize    = AXI_SIZE_4B;
    axi_arburst   = AXI_BURST_INCR;
    axi_awburst   = AXI_BURST_INCR;
    axi_wlast     = 1'b1;
  end

  // Valids rise one cycle after entering the address state and are held off while draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      read_q      <= 1'b0;
      lane_q      <= 1'b0;
      cmd_rdy_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      cmd_rdy_q <= (state_d == ST_IDLE);
      if (cmd_hs) begin
        addr_q  <= icb_cmd_addr;
        wdata_q <= icb_cmd_wdata;
        wmask_q <= icb_cmd_wmask;
        read_q  <= icb_cmd_read;
        lane_q  <= icb_cmd_addr[2];
      end
      arvalid_q <= (state_q == ST_RD_AR) & ~ar_hs & ~draining;
      awvalid_q <= (state_q == ST_WR_AWW) & ~aw_done_d & ~draining;
      wvalid_q  <= (state_q == ST_WR_AWW) & ~w_done_d & ~draining;
      aw_done_q <= (state_d == ST_WR_AWW) & aw_done_d;
      w_done_q  <= (state_d == ST_WR_AWW) & w_done_d;
      if (r_beat) begin
        rsp_rdata_q <= lane_rdata;
        rsp_err_q   <= resp_err(axi_rresp, axi_rid != AXI_ID);
      end else if (b_beat) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= resp_err(axi_bresp, axi_bid != AXI_ID);
      end else if (tmo_hit) begin
        rsp_rdata_q <= '0;
        rsp_err_q   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_e203_icb2axi64_bridge.sv
// Directed, table-driven bench for e203_icb2axi64_bridge with a hand-driven AXI slave.
module tb_e203_icb2axi64_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
  logic [31:0] icb_cmd_addr, icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
  logic [31:0] icb_rsp_rdata;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
  logic [31:0] axi_araddr, axi_awaddr;
  logic [3:0]  axi_arid, axi_rid, axi_awid, axi_bid;
  logic [7:0]  axi_arlen, axi_awlen, axi_wstrb;
  logic [2:0]  axi_arsize, axi_awsize;
  logic [1:0]  axi_arburst, axi_awburst, axi_rresp, axi_bresp;
  logic [63:0] axi_rdata, axi_wdata;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
  logic        axi_bvalid, axi_bready;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  e203_icb2axi64_bridge #(.ID_W(4), .AXI_ID(4'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready), .icb_rsp_rdata(icb_rsp_rdata),
    .icb_rsp_err(icb_rsp_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr), .axi_arid(axi_arid),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata), .axi_rresp(axi_rresp),
    .axi_rlast(axi_rlast), .axi_rid(axi_rid),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awaddr(axi_awaddr), .axi_awid(axi_awid),
    .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
    .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid)
  );

  typedef struct {
    bit          rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [63:0] rdata;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic [63:0] exp_wdata;
    logic [7:0]  exp_wstrb;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Poll a DUT output at negedges; 0=cmd_ready 1=arvalid 2=awvalid 3=rsp_valid.
  task automatic wait_for(input int which, input int limit, output bit ok);
    logic s;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      case (which)
        0: s = icb_cmd_ready;
        1: s = axi_arvalid;
        2: s = axi_awvalid;
        default: s = icb_rsp_valid;
      endcase
      if (s) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic send_cmd(input vec_t v);
    bit ok;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = v.rd;
    icb_cmd_addr  = v.addr;
    icb_cmd_wdata = v.wdata;
    icb_cmd_wmask = v.wmask;
    wait_for(0, 20, ok);
    chk("wait_cmd_ready", {63'd0, ok}, 64'd1);
    @(negedge clk);
    icb_cmd_valid = 1'b0;
  endtask

  task automatic finish_vec(input vec_t v, input int idx);
    bit ok;
    if (v.rd) begin
      wait_for(1, 10, ok);
      chk($sformatf("v%0d_wait_ar", idx), {63'd0, ok}, 64'd1);
      chk($sformatf("v%0d_araddr", idx), {32'd0, axi_araddr}, {32'd0, v.addr});
      chk($sformatf("v%0d_ar_ctl", idx), {49'd0, axi_arid, axi_arlen, axi_arsize, axi_arburst},
          {49'd0, 4'd0, 8'd0, 3'b010, 2'b01});
      axi_arready = 1'b1;
      @(negedge clk);
      axi_arready = 1'b0;
      chk($sformatf("v%0d_rready", idx), {63'd0, axi_rready}, 64'd1);
      axi_rvalid = 1'b1; axi_rdata = v.rdata; axi_rresp = v.resp; axi_rid = v.id;
      @(negedge clk);
      axi_rvalid = 1'b0;
    end else begin
      wait_for(2, 10, ok);
      chk($sformatf("v%0d_wait_aw", idx), {63'd0, ok}, 64'd1);
      chk($sformatf("v%0d_awaddr", idx), {32'd0, axi_awaddr}, {32'd0, v.addr});
      chk($sformatf("v%0d_aw_ctl", idx), {48'd0, axi_wvalid, axi_awid, axi_awlen, axi_awsize, axi_awburst},
          {48'd0, 1'b1, 4'd0, 8'd0, 3'b010, 2'b01});
      chk($sformatf("v%0d_wdata", idx), axi_wdata, v.exp_wdata);
      chk($sformatf("v%0d_wstrb_wlast", idx), {55'd0, axi_wlast, axi_wstrb}, {55'd0, 1'b1, v.exp_wstrb});
      axi_awready = 1'b1; axi_wready = 1'b1;
      @(negedge clk);
      axi_awready = 1'b0; axi_wready = 1'b0;
      chk($sformatf("v%0d_bready", idx), {63'd0, axi_bready}, 64'd1);
      axi_bvalid = 1'b1; axi_bresp = v.resp; axi_bid = v.id;
      @(negedge clk);
      axi_bvalid = 1'b0;
    end
    wait_for(3, 5, ok);
    chk($sformatf("v%0d_rsp_valid", idx), {63'd0, ok}, 64'd1);
    chk($sformatf("v%0d_rsp_rdata", idx), {32'd0, icb_rsp_rdata}, {32'd0, v.exp_rdata});
    chk($sformatf("v%0d_rsp_err", idx), {63'd0, icb_rsp_err}, {63'd0, v.exp_err});
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    icb_rsp_ready = 1'b0;
    chk($sformatf("v%0d_rsp_done", idx), {63'd0, icb_rsp_valid}, 64'd0);
  endtask

  initial begin
    vec_t v;
    bit ok;
    vecs[0] = '{1'b1, 32'h8000_0004, 32'h0, 4'h0, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 4'h0, 64'h0, 8'h00, 32'hAAAA_BBBB, 1'b0};
    vecs[1] = '{1'b1, 32'h8000_0008, 32'h0, 4'h0, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 4'h0, 64'h0, 8'h00, 32'hCCCC_DDDD, 1'b0};
    vecs[2] = '{1'b1, 32'h1000_000C, 32'h0, 4'h0, 64'h1111_2222_3333_4444, 2'b01, 4'h0, 64'h0, 8'h00, 32'h1111_2222, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'h0, 4'h0, 64'h0123_4567_89AB_CDEF, 2'b10, 4'h0, 64'h0, 8'h00, 32'h89AB_CDEF, 1'b1};
    vecs[4] = '{1'b1, 32'h0000_0014, 32'h0, 4'h0, 64'h5555_6666_7777_8888, 2'b00, 4'h3, 64'h0, 8'h00, 32'h5555_6666, 1'b1};
    vecs[5] = '{1'b0, 32'h8000_0000, 32'h1234_5678, 4'b0011, 64'h0, 2'b00, 4'h0, 64'h1234_5678_1234_5678, 8'h03, 32'h0, 1'b0};
    vecs[6] = '{1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 4'b1100, 64'h0, 2'b00, 4'h0, 64'hDEAD_BEEF_DEAD_BEEF, 8'hC0, 32'h0, 1'b0};
    vecs[7] = '{1'b0, 32'h0000_0020, 32'h0BAD_F00D, 4'b1111, 64'h0, 2'b00, 4'h5, 64'h0BAD_F00D_0BAD_F00D, 8'h0F, 32'h0, 1'b1};
    vecs[8] = '{1'b0, 32'h0000_002C, 32'hA5A5_5A5A, 4'b1111, 64'h0, 2'b11, 4'h0, 64'hA5A5_5A5A_A5A5_5A5A, 8'hF0, 32'h0, 1'b1};
    vecs[9] = '{1'b0, 32'h0000_0030, 32'h7777_0001, 4'b1000, 64'h0, 2'b01, 4'h0, 64'h7777_0001_7777_0001, 8'h08, 32'h0, 1'b0};

    rst_n = 1'b0;
    icb_cmd_valid = 0; icb_cmd_read = 0; icb_cmd_addr = 0; icb_cmd_wdata = 0; icb_cmd_wmask = 0;
    icb_rsp_ready = 0; axi_arready = 0; axi_rvalid = 0; axi_rdata = 0; axi_rresp = 0; axi_rlast = 1;
    axi_rid = 0; axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0; axi_bid = 0;
    repeat (2) @(negedge clk);
    chk("rst_valids", {57'd0, icb_cmd_ready, icb_rsp_valid, axi_arvalid, axi_awvalid, axi_wvalid,
        axi_rready, axi_bready}, 64'd0);
    chk("rst_addr_strb", {24'd0, axi_araddr, axi_wstrb}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      send_cmd(vecs[i]);
      finish_vec(vecs[i], i);
    end

    // Write with AW accepted three cycles late, W accepted at once.
    v = '{1'b0, 32'h8000_0010, 32'hCAFE_F00D, 4'b0101, 64'h0, 2'b00, 4'h0, 64'h0, 8'h00, 32'h0, 1'b0};
    send_cmd(v);
    wait_for(2, 10, ok);
    chk("dly_wait_aw", {63'd0, ok}, 64'd1);
    chk("dly_a1", {62'd0, axi_awvalid, axi_wvalid}, 64'd3);
    chk("dly_wstrb", {56'd0, axi_wstrb}, 64'h05);
    axi_wready = 1'b1;
    @(negedge clk);
    axi_wready = 1'b0;
    chk("dly_a2", {30'd0, axi_awaddr, axi_awvalid, axi_wvalid}, {30'd0, 32'h8000_0010, 2'b10});
    @(negedge clk);
    chk("dly_a3", {30'd0, axi_awaddr, axi_awvalid, axi_wvalid}, {30'd0, 32'h8000_0010, 2'b10});
    @(negedge clk);
    chk("dly_a4", {30'd0, axi_awaddr, axi_awvalid, axi_wvalid}, {30'd0, 32'h8000_0010, 2'b10});
    axi_awready = 1'b1;
    @(negedge clk);
    axi_awready = 1'b0;
    chk("dly_a5", {61'd0, axi_awvalid, axi_wvalid, axi_bready}, 64'd1);
    axi_bvalid = 1'b1; axi_bresp = 2'b00; axi_bid = 4'h0;
    @(negedge clk);
    axi_bvalid = 1'b0;
    chk("dly_rsp", {61'd0, icb_rsp_valid, axi_bready, icb_rsp_err}, 64'b100);
    @(negedge clk);
    chk("dly_rsp_hold", {63'd0, icb_rsp_valid}, 64'd1);
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    icb_rsp_ready = 1'b0;
    chk("dly_rsp_done", {63'd0, icb_rsp_valid}, 64'd0);

    // Reset while waiting for R, then a clean read.
    send_cmd(vecs[0]);
    wait_for(1, 10, ok);
    chk("mid_wait_ar", {63'd0, ok}, 64'd1);
    axi_arready = 1'b1;
    @(negedge clk);
    axi_arready = 1'b0;
    chk("mid_rready", {63'd0, axi_rready}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {58'd0, icb_cmd_ready, icb_rsp_valid, axi_arvalid, axi_awvalid, axi_rready,
        axi_bready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_norsp", {63'd0, icb_rsp_valid}, 64'd0);
    send_cmd(vecs[1]);
    finish_vec(vecs[1], 11);

`ifdef E203_ICB2AXI_TIMEOUT_EN
    v = '{1'b1, 32'h0000_0040, 32'h0, 4'h0, 64'h0, 2'b00, 4'h0, 64'h0, 8'h00, 32'h0, 1'b1};
    send_cmd(v);
    wait_for(1, 10, ok);
    chk("tmo_wait_ar", {63'd0, ok}, 64'd1);
    axi_arready = 1'b1;
    @(negedge clk);
    axi_arready = 1'b0;
    wait_for(3, 70000, ok);
    chk("tmo_rsp_valid", {63'd0, ok}, 64'd1);
    chk("tmo_rsp", {31'd0, icb_rsp_rdata, icb_rsp_err}, 64'd1);
    chk("tmo_drain_rready", {63'd0, axi_rready}, 64'd1);
    icb_rsp_ready = 1'b1;
    @(negedge clk);
    icb_rsp_ready = 1'b0;
    v = '{1'b1, 32'h0000_0044, 32'h0, 4'h0, 64'h9999_8888_7777_6666, 2'b00, 4'h0, 64'h0, 8'h00, 32'h9999_8888, 1'b0};
    send_cmd(v);
    for (int i = 0; i < 3; i++) begin
      chk("tmo_ar_blocked", {63'd0, axi_arvalid}, 64'd0);
      @(negedge clk);
    end
    axi_rvalid = 1'b1; axi_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clk);
    axi_rvalid = 1'b0;
    finish_vec(v, 20);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/e203_icb2axi64_bridge.md
Name: e203_icb2axi64_bridge

Overview:
- Converts the e203 SoC's 32-bit ICB system-memory bus into single-beat AXI4 transactions on the 64-bit master port of the chip top.
- Sits directly upstream of the top-level AXI master pins and drives axi_ar*/aw*/w* from core ICB commands.
- One transaction outstanding; the bridge performs 32-to-64-bit lane steering and maps responses back to ICB.

Parameters:
AXI_ID, 4'd0, value driven on arid/awid; response IDs are compared against it.
ID_W, 4, AXI ID width.

Ports:
clk  in  1  single clock.
rst_n  in  1  reset; asynchronous assert, active-low.
icb_cmd_valid  in  1  ICB command valid.
icb_cmd_ready  out  1  ICB command accepted.
icb_cmd_addr  in  32  byte address.
icb_cmd_read  in  1  1=read, 0=write.
icb_cmd_wdata  in  32  write data.
icb_cmd_wmask  in  4  byte enables.
icb_rsp_valid  out  1  ICB response valid.
icb_rsp_ready  in  1  ICB response accepted.
icb_rsp_rdata  out  32  read data.
icb_rsp_err  out  1  bus error.
axi_arvalid/arready  out/in  1  AR handshake.
axi_araddr  out  32; axi_arid out ID_W; axi_arlen out 8; axi_arsize out 3; axi_arburst out 2.
axi_rvalid/rready  in/out  1; axi_rdata in 64; axi_rresp in 2; axi_rlast in 1; axi_rid in ID_W.
axi_awvalid/awready  out/in  1; axi_awaddr out 32; axi_awid out ID_W; axi_awlen out 8; axi_awsize out 3; axi_awburst out 2.
axi_wvalid/wready  out/in  1; axi_wdata out 64; axi_wstrb out 8; axi_wlast out 1.
axi_bvalid/bready  in/out  1; axi_bresp in 2; axi_bid in ID_W.

Behaviour:
- Constants: arlen=awlen=0, arsize=awsize=3'b010, arburst=awburst=2'b01, wlast=1, arid=awid=AXI_ID.
- FSM states: IDLE, RD_AR, RD_R, WR_AWW, WR_B, RSP.
- Reset: all outputs 0 and FSM in IDLE. Holding registers are cleared to 0.
- IDLE:
  - icb_cmd_ready=1.
  - On cmd handshake, latch addr, read, wdata, wmask and lane=addr[2].
  - Go to RD_AR (read) or WR_AWW (write). The AR/AW valid registers assert on the next cycle.
- RD_AR: arvalid=1 and araddr=latched addr. arvalid holds until arready, then go to RD_R.
- RD_R: rready=1.
  - On rvalid, capture rdata[63:32] if lane=1, else rdata[31:0].
  - err = (rresp[1] | rid!=AXI_ID).
  - Go to RSP.
- WR_AWW: awvalid and wvalid assert in the same cycle.
  - wdata = {wdata,wdata}.
  - wstrb = lane ? {wmask,4'b0} : {4'b0,wmask}.
  - Each valid drops independently after its own handshake, in either order.
  - When both handshakes have completed, go to WR_B.
  - W is never sent before AW is presented.
- WR_B: bready=1. On bvalid, err = (bresp[1] | bid!=AXI_ID) and go to RSP.
- RSP: icb_rsp_valid=1 with rdata and err. rdata=0 for writes.
  - Held until icb_rsp_ready, then return to IDLE.
  - The earliest next cmd accept is the cycle after the rsp handshake.
- Latency: read takes a minimum of 4 cycles from cmd accept to rsp valid (zero-wait slave).
- All AXI valids are registered. Address and data are stable while valid is high and ready is low.
- rresp/bresp OKAY and EXOKAY both map to err=0.
- rvalid/bvalid arriving outside RD_R/WR_B is ignored (ready=0).
- Reset mid-transaction immediately returns to IDLE with all valids low. No response is issued.

Optional Feature:
E203_ICB2AXI_TIMEOUT_EN
- Defined: a 16-bit counter runs in RD_R and WR_B and clears on state entry.
  - At count 16'hFFFF, go to RSP with err=1 and rdata=0.
  - Any late R/B beat is then dropped, which requires rready=1 while pending. Track this with one drain flag that blocks the next AR/AW until the stale beat arrives.
- Undefined: no counter, no drain flag. The bridge waits indefinitely.

Decomposition:
- Shared package e203_icb2axi_pkg holds:
  - FSM state typedef.
  - AXI_BURST_INCR=2'b01, AXI_SIZE_4B=3'b010, AXI_RESP_SLVERR=2'b10.
  - TIMEOUT_MAX.
- One natural sub-module: e203_icb2axi_lane, the combinational 32-to-64 steering (wdata/wstrb out, rdata select in), reused for both directions.

Test Plan:
- Read 0x8000_0004, R rdata=64'hAAAA_BBBB_CCCC_DDDD, rresp=0 -> araddr=0x8000_0004, arsize=2, arlen=0; rsp rdata=32'hAAAA_BBBB, err=0.
- Write 0x8000_0000, wdata=32'h1234_5678, wmask=4'b0011 -> wdata=64'h1234_5678_1234_5678, wstrb=8'h03, wlast=1; rsp err=0.
- Write with awready delayed 3 cycles and wready immediate -> wvalid drops after 1 cycle, awvalid is held stable for 4 cycles; single bready handshake; one rsp.
- Read with rresp=2'b10, then write with bid!=AXI_ID -> both rsp err=1.
- rst_n asserted in RD_R -> outputs 0 immediately; a following read completes normally.
- Timeout enabled, no rvalid for 65535 cycles -> rsp err=1; the late rvalid is drained; the next AR is issued only after the drain.
